// File: rtl/seq_pkg.sv
// Shared types and constants for the pipeline sequencer and its hazard detector.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_PAUSED = 3'd2,
      S_STEP   = 3'd3,
      S_DRAIN  = 3'd4,
      S_HALTED = 3'd5
   } seq_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detector
   import seq_pkg::*;
(
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   output logic       load_use_o
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign w_rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is hard-wired, so a load targeting it never creates a dependency
   assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencing and hazard priority mux for the 5-stage core.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | out of reset, core frozen, waiting for run or step
//   S_RUN    | free-running, hazards resolved every cycle
//   S_PAUSED | broken into by a step command or a finished step, frozen
//   S_STEP   | exactly one advanced cycle
//   S_DRAIN  | halt seen, older instructions retiring, front end bubbled
//   S_HALTED | terminal, only reset leaves
module pipeline_sequencer
   import seq_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
)(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic        ex_mem_read_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        redirect_req_i,
   input  logic        halt_detected_i,
   input  logic        cmd_run_i,
   input  logic        cmd_step_i,
   output logic        core_en_o,
   output logic        pc_we_o,
   output logic        if_id_we_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        halted_o,
   output logic        step_done_o,
   output logic [31:0] cycle_count_o
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   seq_state_e    r_state;
   seq_state_e    w_state_nxt;
   logic [DW-1:0] r_drain_cnt;
   logic          r_step_done;
   logic [31:0]   r_cycle_count;
   logic          w_load_use;
   logic          w_drain_enter;

   load_use_detector u_load_use (
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .ex_mem_read_i (ex_mem_read_i),
      .ex_rd_i       (ex_rd_i),
      .load_use_o    (w_load_use)
   );

   always_comb begin
      w_state_nxt   = r_state;
      core_en_o     = 1'b0;
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      halted_o      = 1'b0;

      case (r_state)
         S_IDLE, S_PAUSED: begin
            if (cmd_run_i)       w_state_nxt = S_RUN;
            else if (cmd_step_i) w_state_nxt = S_STEP;
         end
         S_RUN: begin
            if (halt_detected_i) w_state_nxt = S_DRAIN;
            else if (cmd_step_i) w_state_nxt = S_PAUSED;
         end
         S_STEP: begin
            w_state_nxt = halt_detected_i ? S_DRAIN : S_PAUSED;
         end
         S_DRAIN: begin
            if (r_drain_cnt == '0) w_state_nxt = S_HALTED;
         end
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_IDLE;
      endcase

      if (r_state == S_RUN || r_state == S_STEP) begin
         core_en_o = 1'b1;
         if (halt_detected_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (redirect_req_i) begin
            // the ID instruction is wrong-path, so its load-use stall is moot
            pc_we_o       = 1'b1;
            if_id_we_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (w_load_use) begin
            id_ex_flush_o = 1'b1;
         end else begin
            pc_we_o    = 1'b1;
            if_id_we_o = 1'b1;
         end
      end else if (r_state == S_DRAIN) begin
         core_en_o     = 1'b1;
         id_ex_flush_o = 1'b1;
      end else if (r_state == S_HALTED) begin
         halted_o = 1'b1;
      end
   end

   assign w_drain_enter = (r_state != S_DRAIN) && (w_state_nxt == S_DRAIN);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state       <= S_IDLE;
         r_drain_cnt   <= '0;
         r_step_done   <= 1'b0;
         r_cycle_count <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_step_done <= (r_state == S_STEP) && !halt_detected_i;
         if (w_drain_enter)
            r_drain_cnt <= DRAIN_LOAD;
         else if (r_state == S_DRAIN && r_drain_cnt != '0)
            r_drain_cnt <= r_drain_cnt - 1'b1;
         if (core_en_o)
            r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign step_done_o   = r_step_done;
   assign cycle_count_o = r_cycle_count;

endmodule
